// File: rtl/icmp_pkg.sv
// Shared definitions for the ICMP receive path: FSM states, type codes,
// header field positions and checksum helpers.
package icmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TDATA = 2'd1,
        ST_DATA  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    localparam logic [7:0] ECHO_REPLY      = 8'd0;
    localparam logic [7:0] DEST_UNREACH    = 8'd3;
    localparam logic [7:0] SOURCE_QUENCH   = 8'd4;
    localparam logic [7:0] REDIRECT        = 8'd5;
    localparam logic [7:0] ECHO_REQUEST    = 8'd8;
    localparam logic [7:0] TIME_EXCEEDED   = 8'd11;
    localparam logic [7:0] PARAM_PROBLEM   = 8'd12;
    localparam logic [7:0] TIMESTAMP       = 8'd13;
    localparam logic [7:0] TIMESTAMP_REPLY = 8'd14;

    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 24;
    localparam int CODE_MSB = 23;
    localparam int CODE_LSB = 16;
    localparam int CSUM_MSB = 15;
    localparam int CSUM_LSB = 0;

    localparam logic [15:0] CHECKSUM_GOOD = 16'hFFFF;

    // Wide enough to sum every 16-bit half of the message without overflow.
    function automatic int acc_width(input int payload_words);
        return 16 + $clog2(2 * (payload_words + 2));
    endfunction

    function automatic logic type_known(input logic [7:0] t);
        return t inside {ECHO_REPLY, DEST_UNREACH, SOURCE_QUENCH, REDIRECT, ECHO_REQUEST,
                         TIME_EXCEEDED, PARAM_PROBLEM, TIMESTAMP, TIMESTAMP_REPLY};
    endfunction

endpackage

// File: rtl/icmp_receiver_if.sv
// Word-stream handshake into the ICMP receiver (transfer = in_valid & in_ready).
interface icmp_receiver_if;
    logic        in_valid;
    logic        in_sof;
    logic [31:0] in_word;
    logic        in_ready;

    modport master (output in_valid, output in_sof, output in_word, input in_ready);
    modport slave  (input in_valid, input in_sof, input in_word, output in_ready);
endinterface

// File: rtl/icmp_csum_acc.sv
// One's-complement checksum accumulator: load/add 32-bit words as two halves,
// fold twice combinationally and flag an all-ones result.
module icmp_csum_acc
    import icmp_pkg::*;
#(
    parameter int AW = 20
) (
    input  logic        clock,
    input  logic        hardreset,
    input  logic        load,
    input  logic        add,
    input  logic [31:0] word,
    output logic        good
);
    logic [AW-1:0] acc;
    logic [AW-1:0] word_sum;
    logic [16:0]   fold1;
    logic [15:0]   fold2;

    assign word_sum = AW'(word[31:16]) + AW'(word[15:0]);

    always_ff @(posedge clock or posedge hardreset) begin
        if (hardreset) begin
            acc <= '0;
        end else if (load) begin
            acc <= word_sum;
        end else if (add) begin
            acc <= acc + word_sum;
        end
    end

    // The second fold absorbs the carry the first one can produce.
    assign fold1 = 17'(acc[15:0]) + 17'(acc[AW-1:16]);
    assign fold2 = fold1[15:0] + {15'b0, fold1[16]};
    assign good  = (fold2 == CHECKSUM_GOOD);

endmodule

// File: rtl/icmp_receiver.sv
// ICMP receiver: captures header/typedata/payload and checks the RFC 1071 checksum.
// Define ICMP_TYPE_CHECK_EN to add type_err for unrecognised types with a good checksum.
module icmp_receiver
    import icmp_pkg::*;
#(
    parameter int PAYLOAD_WORDS = 3
) (
    input  logic                       clock,
    input  logic                       hardreset,
    icmp_receiver_if.slave             rx,
    output logic [7:0]                 typeoficmp,
    output logic [7:0]                 code,
    output logic [15:0]                rx_checksum,
    output logic [31:0]                typedata,
    output logic [32*PAYLOAD_WORDS-1:0] payload,
    output logic                       msg_valid,
    output logic                       csum_err,
`ifdef ICMP_TYPE_CHECK_EN
    output logic                       type_err,
`endif
    output logic                       frame_err
);
    localparam int AW = acc_width(PAYLOAD_WORDS);
    localparam int CW = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          xfer, last_word, csum_good;
    logic          acc_load, acc_add;
    logic          msg_valid_nxt, csum_err_nxt, frame_err_nxt;
`ifdef ICMP_TYPE_CHECK_EN
    logic          type_err_nxt;
`endif

    assign rx.in_ready = !hardreset && (state != ST_CHECK);
    assign xfer        = rx.in_valid && rx.in_ready;
    assign last_word   = (cnt == CW'(PAYLOAD_WORDS - 1));

    always_ff @(posedge clock or posedge hardreset) begin
        if (hardreset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An sof word in any receiving state restarts the message at typedata.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (xfer && rx.in_sof) state_nxt = ST_TDATA;
            ST_TDATA: if (xfer) state_nxt = rx.in_sof ? ST_TDATA : ST_DATA;
            ST_DATA:  if (xfer) state_nxt = rx.in_sof ? ST_TDATA : (last_word ? ST_CHECK : ST_DATA);
            ST_CHECK: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_load      = xfer && rx.in_sof;
        acc_add       = xfer && !rx.in_sof && (state == ST_TDATA || state == ST_DATA);
        frame_err_nxt = xfer && rx.in_sof && (state == ST_TDATA || state == ST_DATA);
        csum_err_nxt  = (state == ST_CHECK) && !csum_good;
`ifdef ICMP_TYPE_CHECK_EN
        msg_valid_nxt = (state == ST_CHECK) && csum_good && type_known(typeoficmp);
        type_err_nxt  = (state == ST_CHECK) && csum_good && !type_known(typeoficmp);
`else
        msg_valid_nxt = (state == ST_CHECK) && csum_good;
`endif
    end

    always_ff @(posedge clock or posedge hardreset) begin
        if (hardreset) begin
            cnt         <= '0;
            typeoficmp  <= '0;
            code        <= '0;
            rx_checksum <= '0;
            typedata    <= '0;
            payload     <= '0;
            msg_valid   <= 1'b0;
            csum_err    <= 1'b0;
            frame_err   <= 1'b0;
`ifdef ICMP_TYPE_CHECK_EN
            type_err    <= 1'b0;
`endif
        end else begin
            msg_valid <= msg_valid_nxt;
            csum_err  <= csum_err_nxt;
            frame_err <= frame_err_nxt;
`ifdef ICMP_TYPE_CHECK_EN
            type_err  <= type_err_nxt;
`endif
            if (acc_load) begin
                typeoficmp  <= rx.in_word[TYPE_MSB:TYPE_LSB];
                code        <= rx.in_word[CODE_MSB:CODE_LSB];
                rx_checksum <= rx.in_word[CSUM_MSB:CSUM_LSB];
                cnt         <= '0;
            end else if (acc_add && state == ST_TDATA) begin
                typedata <= rx.in_word;
                cnt      <= '0;
            end else if (acc_add && state == ST_DATA) begin
                payload[32*int'(cnt) +: 32] <= rx.in_word;
                cnt <= cnt + 1'b1;
            end
        end
    end

    icmp_csum_acc #(.AW(AW)) u_csum (
        .clock     (clock),
        .hardreset (hardreset),
        .load      (acc_load),
        .add       (acc_add),
        .word      (rx.in_word),
        .good      (csum_good)
    );

endmodule

// File: tb/tb_icmp_receiver.sv
// Bench for icmp_receiver: directed scenarios plus randomized messages against
// a 16-bit end-around-carry checksum model.
module tb_icmp_receiver;
    import icmp_pkg::*;

    localparam int PW = 3;
    localparam logic [3:0] P_NONE  = 4'b0000;
    localparam logic [3:0] P_TYPE  = 4'b0001;
    localparam logic [3:0] P_MSG   = 4'b0010;
    localparam logic [3:0] P_CSUM  = 4'b0100;
    localparam logic [3:0] P_FRAME = 4'b1000;

    logic clock = 1'b0;
    logic hardreset;
    always #5 clock = ~clock;

    icmp_receiver_if rx_if();

    logic [7:0]        typeoficmp, code;
    logic [15:0]       rx_checksum;
    logic [31:0]       typedata;
    logic [32*PW-1:0]  payload;
    logic              msg_valid, csum_err, frame_err, type_err_s;

    icmp_receiver #(.PAYLOAD_WORDS(PW)) dut (
        .clock       (clock),
        .hardreset   (hardreset),
        .rx          (rx_if),
        .typeoficmp  (typeoficmp),
        .code        (code),
        .rx_checksum (rx_checksum),
        .typedata    (typedata),
        .payload     (payload),
        .msg_valid   (msg_valid),
        .csum_err    (csum_err),
`ifdef ICMP_TYPE_CHECK_EN
        .type_err    (type_err_s),
`endif
        .frame_err   (frame_err)
    );
`ifndef ICMP_TYPE_CHECK_EN
    assign type_err_s = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;
    int msg_cnt = 0;
    int csum_cnt = 0;

    always @(negedge clock) begin
        if ($countones({msg_valid, csum_err, frame_err, type_err_s}) > 1) overlap_cnt++;
        if (msg_valid) msg_cnt++;
        if (csum_err) csum_cnt++;
    end

    function automatic logic [3:0] pulses();
        return {frame_err, csum_err, msg_valid, type_err_s};
    endfunction

    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'b0, s[16]};
    endfunction

    function automatic logic [15:0] ones_sum(input logic [31:0] w[$]);
        logic [15:0] s;
        s = 16'h0;
        foreach (w[i]) begin
            s = ones_add(s, w[i][31:16]);
            s = ones_add(s, w[i][15:0]);
        end
        return s;
    endfunction

    function automatic logic [3:0] model_outcome(input logic [31:0] w[$]);
        logic [7:0] t;
        t = w[0][31:24];
        if (ones_sum(w) != 16'hFFFF) return P_CSUM;
`ifdef ICMP_TYPE_CHECK_EN
        if (!(t inside {8'd0, 8'd3, 8'd4, 8'd5, 8'd8, 8'd11, 8'd12, 8'd13, 8'd14})) return P_TYPE;
`else
        if (t === 8'hxx) return P_NONE;
`endif
        return P_MSG;
    endfunction

    // Present one word from a negedge; returns at the negedge after it was accepted.
    task automatic send_word(input logic [31:0] w, input logic sof);
        int guard;
        guard = 0;
        rx_if.in_valid = 1'b1;
        rx_if.in_sof   = sof;
        rx_if.in_word  = w;
        while (rx_if.in_ready !== 1'b1 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++;
            $display("FAIL ready_timeout: in_ready=%b, required 1 within 20 cycles", rx_if.in_ready);
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        rx_if.in_valid = 1'b0;
        rx_if.in_sof   = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_msg(input logic [31:0] w[$], input int gap);
        foreach (w[i]) begin
            send_word(w[i], i == 0);
            if (gap > 0 && i != w.size() - 1) idle(gap);
        end
    endtask

    // Pulse vectors in the CHECK cycle, the following cycle and the one after.
    task automatic wait_result(output logic [3:0] p1, output logic [3:0] p2,
                               output logic [3:0] p3, output logic r1);
        idle(0);
        p1 = pulses();
        r1 = rx_if.in_ready;
        @(negedge clock);
        p2 = pulses();
        @(negedge clock);
        p3 = pulses();
    endtask

    logic [31:0] s1[$] = '{32'h08002B30, 32'h00010002, 32'h11111111, 32'h22222222, 32'h33333333};

    task automatic test_reset();
        hardreset = 1'b1;
        idle(2);
        checks++;
        if (rx_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", rx_if.in_ready); end
        checks++;
        if ({typeoficmp, code, rx_checksum, typedata, payload} !== '0) begin
            errors++; $display("FAIL reset_fields: got %h, required 0", {typeoficmp, code, rx_checksum, typedata, payload});
        end
        checks++;
        if (pulses() !== P_NONE) begin errors++; $display("FAIL reset_pulses: got %b, required 0000", pulses()); end
        hardreset = 1'b0;
        @(negedge clock);
        checks++;
        if (rx_if.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b, required 1", rx_if.in_ready); end
    endtask

    task automatic test_good_echo(input int gap, input string tag);
        logic [3:0] p1, p2, p3;
        logic r1;
        send_msg(s1, gap);
        wait_result(p1, p2, p3, r1);
        checks++;
        if (p1 !== P_NONE || p2 !== P_MSG || p3 !== P_NONE) begin
            errors++; $display("FAIL %s_pulse: got %b/%b/%b, required 0000/0010/0000", tag, p1, p2, p3);
        end
        checks++;
        if (r1 !== 1'b0) begin errors++; $display("FAIL %s_check_ready: got %b, required 0", tag, r1); end
        checks++;
        if (typeoficmp !== 8'd8 || code !== 8'd0 || rx_checksum !== 16'h2B30) begin
            errors++; $display("FAIL %s_header: got %h %h %h, required 08 00 2b30", tag, typeoficmp, code, rx_checksum);
        end
        checks++;
        if (typedata !== 32'h00010002 || payload !== {32'h33333333, 32'h22222222, 32'h11111111}) begin
            errors++; $display("FAIL %s_body: got %h %h, required 00010002 333333332222222211111111", tag, typedata, payload);
        end
    endtask

    task automatic test_bad_csum();
        logic [31:0] w[$];
        logic [3:0] p1, p2, p3;
        logic r1;
        w = s1;
        w[0] = 32'h08002B31;
        send_msg(w, 0);
        wait_result(p1, p2, p3, r1);
        checks++;
        if (p1 !== P_NONE || p2 !== P_CSUM || p3 !== P_NONE) begin
            errors++; $display("FAIL bad_csum_pulse: got %b/%b/%b, required 0000/0100/0000", p1, p2, p3);
        end
        checks++;
        if (rx_checksum !== 16'h2B31 || typedata !== 32'h00010002) begin
            errors++; $display("FAIL bad_csum_fields: got %h %h, required 2b31 00010002", rx_checksum, typedata);
        end
    endtask

    task automatic test_frame_restart();
        logic [3:0] p1, p2, p3;
        logic r1;
        send_word(32'h0B00FFFF, 1'b1);
        send_word(32'hDEADBEEF, 1'b0);
        send_word(s1[0], 1'b1);
        checks++;
        if (pulses() !== P_FRAME) begin errors++; $display("FAIL frame_pulse: got %b, required 1000", pulses()); end
        for (int i = 1; i < 5; i++) send_word(s1[i], 1'b0);
        wait_result(p1, p2, p3, r1);
        checks++;
        if (p1 !== P_NONE || p2 !== P_MSG || p3 !== P_NONE) begin
            errors++; $display("FAIL frame_restart_msg: got %b/%b/%b, required 0000/0010/0000", p1, p2, p3);
        end
        checks++;
        if (typeoficmp !== 8'd8 || rx_checksum !== 16'h2B30) begin
            errors++; $display("FAIL frame_restart_header: got %h %h, required 08 2b30", typeoficmp, rx_checksum);
        end
    endtask

    task automatic test_reset_abort();
        logic [3:0] seen, p1, p2, p3;
        logic r1;
        for (int i = 0; i < 3; i++) send_word(s1[i], i == 0);
        rx_if.in_valid = 1'b0;
        hardreset = 1'b1;
        seen = P_NONE;
        repeat (2) begin @(negedge clock); seen |= pulses(); end
        hardreset = 1'b0;
        repeat (4) begin @(negedge clock); seen |= pulses(); end
        checks++;
        if (seen !== P_NONE) begin errors++; $display("FAIL abort_no_pulse: got %b, required 0000", seen); end
        send_msg(s1, 0);
        wait_result(p1, p2, p3, r1);
        checks++;
        if (p2 !== P_MSG) begin errors++; $display("FAIL abort_replay: got %b, required 0010", p2); end
    endtask

    task automatic test_type_check();
        logic [31:0] w[$];
        logic [3:0] p1, p2, p3, exp;
        logic r1;
        w = s1;
        w[0] = 32'h07002C30;
`ifdef ICMP_TYPE_CHECK_EN
        exp = P_TYPE;
`else
        exp = P_MSG;
`endif
        send_msg(w, 1);
        wait_result(p1, p2, p3, r1);
        checks++;
        if (p1 !== P_NONE || p2 !== exp || p3 !== P_NONE) begin
            errors++; $display("FAIL type_check: got %b/%b/%b, required 0000/%b/0000", p1, p2, p3, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[$];
        logic [3:0] p1, p2, p3;
        logic r1;
        int m0, c0;
        w = s1;
        w[3] = 32'h22222223;
        m0 = msg_cnt;
        c0 = csum_cnt;
        send_msg(s1, 0);
        send_msg(w, 0);
        wait_result(p1, p2, p3, r1);
        checks++;
        if (msg_cnt - m0 !== 1 || csum_cnt - c0 !== 1) begin
            errors++; $display("FAIL back_to_back: got msg=%0d csum=%0d, required 1 1", msg_cnt - m0, csum_cnt - c0);
        end
    endtask

    task automatic test_random(input int n);
        logic [7:0] known[9] = '{8'd0, 8'd3, 8'd4, 8'd5, 8'd8, 8'd11, 8'd12, 8'd13, 8'd14};
        logic [31:0] w[$];
        logic [3:0] p1, p2, p3, exp;
        logic [15:0] cs;
        logic r1;
        for (int it = 0; it < n; it++) begin
            logic [7:0] t;
            t = ($urandom_range(0, 2) != 0) ? known[$urandom_range(0, 8)] : 8'($urandom);
            w = {};
            w.push_back({t, 8'($urandom), 16'h0});
            for (int i = 0; i < PW + 1; i++) w.push_back($urandom);
            cs = ~ones_sum(w);
            w[0][15:0] = cs;
            if ($urandom_range(0, 3) == 0) begin
                int k;
                k = $urandom_range(0, PW + 1);
                w[k][$urandom_range(0, 31)] ^= 1'b1;
            end
            exp = model_outcome(w);
            repeat ($urandom_range(0, 2)) send_word($urandom, 1'b0);
            foreach (w[i]) begin
                send_word(w[i], i == 0);
                if (i != PW + 1) idle($urandom_range(0, 2));
            end
            wait_result(p1, p2, p3, r1);
            checks++;
            if (p1 !== P_NONE || p2 !== exp || p3 !== P_NONE) begin
                errors++; $display("FAIL rand%0d_pulse: got %b/%b/%b, required 0000/%b/0000", it, p1, p2, p3, exp);
            end
            checks++;
            if ({typeoficmp, code, rx_checksum} !== w[0] || typedata !== w[1] ||
                payload !== {w[4], w[3], w[2]}) begin
                errors++; $display("FAIL rand%0d_fields: got %h %h %h, required %h %h %h", it,
                                   {typeoficmp, code, rx_checksum}, typedata, payload, w[0], w[1], {w[4], w[3], w[2]});
            end
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (overlap_cnt !== 0) begin errors++; $display("FAIL pulse_exclusive: got %0d overlaps, required 0", overlap_cnt); end
    endtask

    initial begin
        hardreset      = 1'b1;
        rx_if.in_valid = 1'b0;
        rx_if.in_sof   = 1'b0;
        rx_if.in_word  = '0;
        test_reset();
        test_good_echo(0, "good_echo");
        test_bad_csum();
        test_good_echo(3, "gapped_echo");
        test_frame_restart();
        test_reset_abort();
        test_type_check();
        test_back_to_back();
        test_random(40);
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
